load_store_unit: RTL and testbench

Pipeline-side initiator for the word-organised data memory. Accepts one load or store request at a time from the MEM stage and converts byte addresses to word indices. Drives the memory's MemRead/MemWrite/Addr/WriteData and performs byte-lane extraction with sign/zero extension. Implements sub-word stores as a read-modify-write sequence and flags misaligned or illegal accesses without touching memory.

---
 rtl/load_store_unit.sv | 136 +++++++++++++
 tb/tb_load_store_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store initiator between the MEM stage and a word-organised data memory.
// Handles byte/half lane extraction with extension, and sub-word stores by read-modify-write.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  is_store_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] load_data_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_write_data_o,
    output logic                  mem_write_o,
    output logic                  mem_read_o,
    input  logic [DATA_WIDTH-1:0] mem_data_read_i
);

    typedef enum logic [1:0] {IDLE, LOAD, STORE_RD, STORE_WR} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [1:0]            offset_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic [DATA_WIDTH-1:0] store_data_q;
    logic [DATA_WIDTH-1:0] merge_q;
    logic [DATA_WIDTH-1:0] load_data_q;
    logic                  done_q;
    logic                  err_q;

    logic                  access_illegal;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [DATA_WIDTH-1:0] load_ext_d;
    logic [DATA_WIDTH-1:0] write_word_d;

    assign access_illegal = (size_i == 2'b11) ||
                            (size_i == 2'b10 && addr_i[1:0] != 2'b00) ||
                            (size_i == 2'b01 && addr_i[0]);

    // Lane select is little-endian; the write word splices the new lane into the word read in STORE_RD.
    always_comb begin
        byte_lane    = mem_data_read_i[{offset_q, 3'b000} +: 8];
        half_lane    = mem_data_read_i[{offset_q[1], 4'b0000} +: 16];
        load_ext_d   = mem_data_read_i;
        write_word_d = store_data_q;
        case (size_q)
            2'b00: begin
                load_ext_d   = {{(DATA_WIDTH-8){~unsigned_q & byte_lane[7]}}, byte_lane};
                write_word_d = merge_q;
                write_word_d[{offset_q, 3'b000} +: 8] = store_data_q[7:0];
            end
            2'b01: begin
                load_ext_d   = {{(DATA_WIDTH-16){~unsigned_q & half_lane[15]}}, half_lane};
                write_word_d = merge_q;
                write_word_d[{offset_q[1], 4'b0000} +: 16] = store_data_q[15:0];
            end
            default: begin
                load_ext_d   = mem_data_read_i;
                write_word_d = store_data_q;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            offset_q     <= '0;
            size_q       <= '0;
            unsigned_q   <= 1'b0;
            store_data_q <= '0;
            merge_q      <= '0;
            load_data_q  <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        mem_addr_q   <= {2'b00, addr_i[ADDR_WIDTH-1:2]};
                        offset_q     <= addr_i[1:0];
                        size_q       <= size_i;
                        unsigned_q   <= unsigned_i;
                        store_data_q <= store_data_i;
                        // Illegal accesses never leave IDLE, so memory is never touched.
                        if (access_illegal) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else if (!is_store_i) begin
                            state_q <= LOAD;
                        end else if (size_i == 2'b10) begin
                            state_q <= STORE_WR;
                        end else begin
                            state_q <= STORE_RD;
                        end
                    end
                end
                LOAD: begin
                    load_data_q <= load_ext_d;
                    done_q      <= 1'b1;
                    state_q     <= IDLE;
                end
                STORE_RD: begin
                    merge_q <= mem_data_read_i;
                    state_q <= STORE_WR;
                end
                STORE_WR: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o           = (state_q != IDLE);
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign load_data_o      = load_data_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_write_data_o = write_word_d;
    assign mem_read_o       = (state_q == LOAD) || (state_q == STORE_RD);
    assign mem_write_o      = (state_q == STORE_WR);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a 16-word memory model plus a byte-array
// reference of what memory and LoadData should hold after each access.
module tb_load_store_unit;

    logic        clk;
    logic        rstN;
    logic        req;
    logic        isStore;
    logic [1:0]  size;
    logic        isUnsigned;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] loadData;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic        memWrite;
    logic        memRead;
    logic [31:0] memDataRead;

    logic [31:0] tbMem [16] = '{default: 32'h0};
    logic [7:0]  refMem [64] = '{default: 8'h0};
    logic [31:0] refLoad;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk_i           (clk),
        .rst_ni          (rstN),
        .req_i           (req),
        .is_store_i      (isStore),
        .size_i          (size),
        .unsigned_i      (isUnsigned),
        .addr_i          (addr),
        .store_data_i    (storeData),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err),
        .load_data_o     (loadData),
        .mem_addr_o      (memAddr),
        .mem_write_data_o(memWriteData),
        .mem_write_o     (memWrite),
        .mem_read_o      (memRead),
        .mem_data_read_i (memDataRead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read, write on the rising edge after MemWrite.
    assign memDataRead = tbMem[memAddr[3:0]];
    always @(posedge clk) begin
        if (memWrite) tbMem[memAddr[3:0]] <= memWriteData;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refWord(input int idx);
        return {refMem[4*idx+3], refMem[4*idx+2], refMem[4*idx+1], refMem[4*idx]};
    endfunction

    // One access through the DUT, checked against the byte-level model.
    task automatic applyStimulus(input bit st, input logic [1:0] sz, input bit uns,
                                 input logic [31:0] a, input logic [31:0] d);
        bit          illegal;
        int          expLat, expReads, expWrites, lat, reads, writes;
        logic [31:0] expWord;
        int          ai;
        ai       = int'(a[5:0]);
        illegal  = (sz == 2'b11) || (sz == 2'b10 && a[1:0] != 2'b00) || (sz == 2'b01 && a[0]);
        expLat   = illegal ? 1 : ((st && sz != 2'b10) ? 3 : 2);
        expReads = illegal ? 0 : ((!st || sz != 2'b10) ? 1 : 0);
        expWrites = (!illegal && st) ? 1 : 0;
        if (!illegal && st) begin
            refMem[ai] = d[7:0];
            if (sz != 2'b00) refMem[ai+1] = d[15:8];
            if (sz == 2'b10) begin
                refMem[ai+2] = d[23:16];
                refMem[ai+3] = d[31:24];
            end
        end else if (!illegal) begin
            case (sz)
                2'b00: refLoad = uns ? {24'h0, refMem[ai]} : {{24{refMem[ai][7]}}, refMem[ai]};
                2'b01: refLoad = uns ? {16'h0, refMem[ai+1], refMem[ai]}
                                     : {{16{refMem[ai+1][7]}}, refMem[ai+1], refMem[ai]};
                default: refLoad = refWord(ai / 4);
            endcase
        end
        expWord = refWord(ai / 4);

        @(negedge clk);
        req = 1'b1; isStore = st; size = sz; isUnsigned = uns; addr = a; storeData = d;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 1; reads = 0; writes = 0;
        while (!done && lat < 10) begin
            if (memRead) reads++;
            if (memWrite) begin
                writes++;
                checkOutput("wrdata", memWriteData, expWord);
            end
            if (memRead || memWrite) checkOutput("memaddr", memAddr, {2'b00, a[31:2]});
            if (memRead && memWrite) checkOutput("rdwr_excl", 32'(memRead & memWrite), 32'h0);
            @(posedge clk);
            #1 lat++;
        end
        checkOutput("latency", lat, expLat);
        checkOutput("err", 32'(err), 32'(illegal));
        checkOutput("busy_at_done", 32'(busy), 32'h0);
        checkOutput("reads", reads, expReads);
        checkOutput("writes", writes, expWrites);
        checkOutput("loaddata", loadData, refLoad);
        @(posedge clk);
        #1 checkOutput("done_clear", {30'h0, done, err}, 32'h0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, {busy, done, err, memRead, memWrite}, 5'h0);
        checkOutput({tag, "_ld"}, loadData, 32'h0);
        checkOutput({tag, "_ma"}, memAddr, 32'h0);
        checkOutput({tag, "_wd"}, memWriteData, 32'h0);
    endtask

    initial begin
        rstN = 1'b0; req = 1'b0; isStore = 1'b0; size = 2'b00; isUnsigned = 1'b0;
        addr = '0; storeData = '0; refLoad = '0;
        #2 checkAllZero("reset");
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1 checkOutput("post_reset", {30'h0, busy, done}, 32'h0);

        // Word store then load at 0x0C
        applyStimulus(1, 2'b10, 0, 32'h0C, 32'hDEADBEEF);
        applyStimulus(0, 2'b10, 0, 32'h0C, 32'h0);
        checkOutput("lw_value", loadData, 32'hDEADBEEF);

        // Byte store merge
        applyStimulus(1, 2'b10, 0, 32'h0C, 32'h11223344);
        applyStimulus(1, 2'b00, 0, 32'h0D, 32'h000000AA);
        checkOutput("sb_merge", tbMem[3], 32'h1122AA44);

        // Load extension
        applyStimulus(1, 2'b10, 0, 32'h0C, 32'h80FF7F00);
        applyStimulus(0, 2'b00, 0, 32'h0E, 32'h0);
        checkOutput("lb", loadData, 32'hFFFFFFFF);
        applyStimulus(0, 2'b00, 1, 32'h0E, 32'h0);
        checkOutput("lbu", loadData, 32'h000000FF);
        applyStimulus(0, 2'b01, 0, 32'h0E, 32'h0);
        checkOutput("lh", loadData, 32'hFFFF80FF);
        applyStimulus(0, 2'b01, 1, 32'h0E, 32'h0);
        checkOutput("lhu", loadData, 32'h000080FF);

        // Illegal accesses
        applyStimulus(0, 2'b10, 0, 32'h0E, 32'h0);
        applyStimulus(1, 2'b01, 0, 32'h0D, 32'h1234);
        applyStimulus(0, 2'b11, 0, 32'h10, 32'h0);
        applyStimulus(1, 2'b11, 0, 32'h10, 32'hCAFEF00D);
        checkOutput("err_keeps_ld", loadData, 32'h000080FF);

        // Req during STORE_RD of a SH must be ignored
        refMem[14] = 8'h5A; refMem[15] = 8'hA5;
        @(negedge clk);
        req = 1'b1; isStore = 1'b1; size = 2'b01; addr = 32'h0E; storeData = 32'h0000A55A;
        @(posedge clk);
        #1 req = 1'b0;
        checkOutput("busy_rd", {30'h0, busy, memRead}, 32'h3);
        @(negedge clk);
        req = 1'b1; isStore = 1'b1; size = 2'b10; addr = 32'h20; storeData = 32'h01020304;
        @(posedge clk);
        #1 req = 1'b0;
        checkOutput("busy_wr", {31'h0, memWrite}, 32'h1);
        checkOutput("busy_wd", memWriteData, 32'hA55A7F00);
        @(posedge clk);
        #1 checkOutput("busy_done", {31'h0, done}, 32'h1);
        @(posedge clk);
        #1 checkOutput("busy_ignored", {29'h0, busy, memRead, memWrite}, 32'h0);

        // Reset aborts a sub-word store before it writes
        @(negedge clk);
        req = 1'b1; isStore = 1'b1; size = 2'b01; addr = 32'h0C; storeData = 32'h0000BBBB;
        @(posedge clk);
        #1 req = 1'b0;
        checkOutput("abort_rd", {31'h0, memRead}, 32'h1);
        #2 rstN = 1'b0;
        #1 checkAllZero("abort");
        refLoad = 32'h0;
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 checkOutput("abort_quiet", {29'h0, done, memWrite, busy}, 32'h0);
        end
        checkOutput("abort_mem", tbMem[3], refWord(3));

        // Randomized accesses
        for (int i = 0; i < 200; i++) begin
            applyStimulus(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          bit'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
        end

        for (int w = 0; w < 16; w++) checkOutput("mem_final", tbMem[w], refWord(w));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
